mmio_lcl_sequencer: RTL and testbench

//  Upstream stage of the AXI-Lite MMIO master shim. Accepts one host MMIO request (32b or 64b) through a

---
 rtl/mmio_seq_pkg.sv | 20 ++
 rtl/mmio_seq_timer.sv | 31 +++
 rtl/mmio_lcl_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mmio_lcl_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_seq_pkg.sv
// Shared types and constants for the MMIO local-bus sequencer.
package mmio_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        WAIT_LO,
        ISSUE_HI,
        WAIT_HI,
        RESP
    } seq_state_t;

    localparam logic [63:0] TIMEOUT_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

    // 64b accesses need 8-byte alignment, 32b accesses need 4-byte alignment.
    function automatic logic is_misaligned(input logic dw, input logic [31:0] addr);
        return dw ? (addr[2:0] != 3'd0) : (addr[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/mmio_seq_timer.sv
// Loadable up-counter with synchronous clear and enable; tc flags the terminal value.
module mmio_seq_timer #(
    parameter int                  CNT_W    = 11,
    parameter logic [CNT_W-1:0]    TC_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VALUE);

endmodule

// File: rtl/mmio_lcl_sequencer.sv
// Sequences one host MMIO request into one or two 32b local-bus accesses and returns a single response.
module mmio_lcl_sequencer
    import mmio_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_CNT_W       = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_dw,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        lcl_mmio_wr,
    output logic        lcl_mmio_rd,
    output logic [31:0] lcl_mmio_addr,
    output logic [31:0] lcl_mmio_din,
    input  logic        lcl_mmio_ack,
    input  logic        lcl_mmio_dv,
    input  logic        lcl_mmio_rsp,
    input  logic [31:0] lcl_mmio_dout
);

    seq_state_t  state, state_n;

    logic        op_wr;
    logic        op_dw;
    logic [31:0] op_addr;
    logic [31:0] op_wdata_hi;

    logic        accept;
    logic        misaligned;
    logic        in_wait;
    logic        done;
    logic        to_tc;
    logic        timer_clr;

    logic        req_ready_n;
    logic        rsp_valid_n;
    logic [63:0] rsp_rdata_n;
    logic        rsp_err_n;
    logic        rsp_timeout_n;
    logic        lcl_mmio_wr_n;
    logic        lcl_mmio_rd_n;
    logic [31:0] lcl_mmio_addr_n;
    logic [31:0] lcl_mmio_din_n;

    assign accept     = req_valid & req_ready;
    assign misaligned = is_misaligned(req_dw, req_addr);
    assign in_wait    = (state == WAIT_LO) || (state == WAIT_HI);
    // Only the strobe matching the access direction completes it.
    assign done       = in_wait & (op_wr ? lcl_mmio_ack : lcl_mmio_dv);
    assign timer_clr  = (state == ISSUE_LO) || (state == ISSUE_HI);

    mmio_seq_timer #(
        .CNT_W    (TO_CNT_W),
        .TC_VALUE (TO_CNT_W'(TIMEOUT_CYCLES - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .en       (in_wait),
        .load     (1'b0),
        .load_val ('0),
        .tc       (to_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_timeout   <= 1'b0;
            lcl_mmio_wr   <= 1'b0;
            lcl_mmio_rd   <= 1'b0;
            lcl_mmio_addr <= '0;
            lcl_mmio_din  <= '0;
            op_wr         <= 1'b0;
            op_dw         <= 1'b0;
            op_addr       <= '0;
            op_wdata_hi   <= '0;
        end else begin
            state         <= state_n;
            req_ready     <= req_ready_n;
            rsp_valid     <= rsp_valid_n;
            rsp_rdata     <= rsp_rdata_n;
            rsp_err       <= rsp_err_n;
            rsp_timeout   <= rsp_timeout_n;
            lcl_mmio_wr   <= lcl_mmio_wr_n;
            lcl_mmio_rd   <= lcl_mmio_rd_n;
            lcl_mmio_addr <= lcl_mmio_addr_n;
            lcl_mmio_din  <= lcl_mmio_din_n;
            if (accept) begin
                op_wr       <= req_wr;
                op_dw       <= req_dw;
                op_addr     <= req_addr;
                op_wdata_hi <= req_wdata[63:32];
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (accept) state_n = misaligned ? RESP : ISSUE_LO;
            ISSUE_LO: state_n = WAIT_LO;
            WAIT_LO: begin
                // A failed lo half of a 64b access skips the hi half.
                if (done)       state_n = (op_dw && lcl_mmio_rsp) ? ISSUE_HI : RESP;
                else if (to_tc) state_n = RESP;
            end
            ISSUE_HI: state_n = WAIT_HI;
            WAIT_HI:  if (done || to_tc) state_n = RESP;
            RESP:     if (rsp_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so every port leaves a flop.
    always_comb begin
        req_ready_n     = (state_n == IDLE);
        rsp_valid_n     = (state_n == RESP);
        rsp_rdata_n     = rsp_rdata;
        rsp_err_n       = rsp_err;
        rsp_timeout_n   = rsp_timeout;
        lcl_mmio_wr_n   = 1'b0;
        lcl_mmio_rd_n   = 1'b0;
        lcl_mmio_addr_n = lcl_mmio_addr;
        lcl_mmio_din_n  = lcl_mmio_din;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    rsp_rdata_n   = '0;
                    rsp_err_n     = misaligned;
                    rsp_timeout_n = 1'b0;
                    if (!misaligned) begin
                        lcl_mmio_wr_n   = req_wr;
                        lcl_mmio_rd_n   = ~req_wr;
                        lcl_mmio_addr_n = req_addr;
                        lcl_mmio_din_n  = req_wdata[31:0];
                    end
                end
            end
            WAIT_LO, WAIT_HI: begin
                if (done) begin
                    rsp_err_n = rsp_err | ~lcl_mmio_rsp;
                    if (!op_wr) begin
                        if (state == WAIT_LO) rsp_rdata_n[31:0]  = lcl_mmio_dout;
                        else                  rsp_rdata_n[63:32] = lcl_mmio_dout;
                    end
                    if (state_n == ISSUE_HI) begin
                        lcl_mmio_wr_n   = op_wr;
                        lcl_mmio_rd_n   = ~op_wr;
                        lcl_mmio_addr_n = op_addr + 32'd4;
                        lcl_mmio_din_n  = op_wdata_hi;
                    end
                end else if (to_tc) begin
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    if (!op_wr) rsp_rdata_n = TIMEOUT_RDATA;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_rdata_n   = '0;
                    rsp_err_n     = 1'b0;
                    rsp_timeout_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mmio_lcl_sequencer.sv
// Bench for mmio_lcl_sequencer: directed vector table, multi-cycle corner sequences and random traffic vs a reference model.
module tb_mmio_lcl_sequencer;

    localparam int TO    = 16;
    localparam int TO_W  = 5;
    localparam int NEVER = 1000;
    localparam int NV    = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_dw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        lcl_mmio_wr;
    logic        lcl_mmio_rd;
    logic [31:0] lcl_mmio_addr;
    logic [31:0] lcl_mmio_din;
    logic        lcl_mmio_ack = 1'b0;
    logic        lcl_mmio_dv = 1'b0;
    logic        lcl_mmio_rsp = 1'b0;
    logic [31:0] lcl_mmio_dout = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_lcl_sequencer #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(TO_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_dw        (req_dw),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .lcl_mmio_wr   (lcl_mmio_wr),
        .lcl_mmio_rd   (lcl_mmio_rd),
        .lcl_mmio_addr (lcl_mmio_addr),
        .lcl_mmio_din  (lcl_mmio_din),
        .lcl_mmio_ack  (lcl_mmio_ack),
        .lcl_mmio_dv   (lcl_mmio_dv),
        .lcl_mmio_rsp  (lcl_mmio_rsp),
        .lcl_mmio_dout (lcl_mmio_dout)
    );

    typedef struct {
        bit          wr;
        bit          dw;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          lat_lo;
        bit          rsp_lo;
        logic [31:0] dout_lo;
        int          lat_hi;
        bit          rsp_hi;
        logic [31:0] dout_hi;
        int          rdy_delay;
    } txn_t;

    typedef struct {
        txn_t        t;
        logic        err;
        logic        to;
        logic [63:0] rdata;
        int          np;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(bit wr, bit dw, logic [31:0] a, logic [63:0] wd,
                                int llo, bit rlo, logic [31:0] dlo,
                                int lhi, bit rhi, logic [31:0] dhi, int rdy);
        txn_t t;
        t.wr = wr; t.dw = dw; t.addr = a; t.wdata = wd;
        t.lat_lo = llo; t.rsp_lo = rlo; t.dout_lo = dlo;
        t.lat_hi = lhi; t.rsp_hi = rhi; t.dout_hi = dhi;
        t.rdy_delay = rdy;
        return t;
    endfunction

    // Reference: walk the accesses a request implies and fold in each outcome.
    function automatic void model(input txn_t t, output logic err, output logic to,
                                  output logic [63:0] rd, output int np);
        int n_acc;
        err = 1'b0; to = 1'b0; rd = '0; np = 0;
        if (t.dw ? (t.addr % 8 != 0) : (t.addr % 4 != 0)) begin
            err = 1'b1;
            return;
        end
        n_acc = t.dw ? 2 : 1;
        for (int i = 0; i < n_acc; i++) begin
            int          lat;
            bit          ok;
            logic [31:0] d;
            lat = (i == 0) ? t.lat_lo : t.lat_hi;
            ok  = (i == 0) ? t.rsp_lo : t.rsp_hi;
            d   = (i == 0) ? t.dout_lo : t.dout_hi;
            np++;
            if (lat > TO) begin
                err = 1'b1; to = 1'b1;
                if (!t.wr) rd = '1;
                return;
            end
            if (!t.wr) rd[32*i +: 32] = d;
            if (!ok) begin
                err = 1'b1;
                return;
            end
        end
    endfunction

    // Entered and left just after a falling edge; acts as host and as local slave.
    task automatic run_txn(input txn_t t, input logic e_err, input logic e_to,
                           input logic [63:0] e_rd, input int e_np, input string tag);
        int k, np, wcnt, lat, last_pulse, last_strobe, exp_k;
        bit pend, seen, acc, ok;
        logic [31:0] d;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = t.wr; req_dw = t.dw; req_addr = t.addr; req_wdata = t.wdata;
        acc = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ".accept"}, 64'(acc), 64'd1);
        if (!acc) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom};
        req_wr    = 1'($urandom);
        req_dw    = 1'($urandom);
        np = 0; pend = 1'b0; seen = 1'b0; wcnt = 0; last_pulse = 0; last_strobe = 0;
        k = 1;
        while (!seen && k <= 200) begin
            lcl_mmio_ack = 1'b0;
            lcl_mmio_dv  = 1'b0;
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                if (lcl_mmio_wr || lcl_mmio_rd) begin
                    chk({tag, ".pulse_kind"}, 64'({lcl_mmio_wr, lcl_mmio_rd}), t.wr ? 64'd2 : 64'd1);
                    chk({tag, ".pulse_allowed"}, 64'(np < e_np), 64'd1);
                    chk({tag, ".pulse_addr"}, 64'(lcl_mmio_addr), 64'(t.addr + 32'(4 * np)));
                    if (t.wr)
                        chk({tag, ".pulse_din"}, 64'(lcl_mmio_din),
                            (np == 0) ? 64'(t.wdata[31:0]) : 64'(t.wdata[63:32]));
                    if (np == 0) chk({tag, ".pulse_latency"}, 64'(k), 64'd1);
                    np++; pend = 1'b1; wcnt = 0; last_pulse = k;
                end else if (pend) begin
                    wcnt++;
                    lat = (np == 1) ? t.lat_lo : t.lat_hi;
                    ok  = (np == 1) ? t.rsp_lo : t.rsp_hi;
                    d   = (np == 1) ? t.dout_lo : t.dout_hi;
                    if (wcnt == lat) begin
                        chk({tag, ".addr_stable"}, 64'(lcl_mmio_addr), 64'(t.addr + 32'(4 * (np - 1))));
                        if (t.wr) lcl_mmio_ack = 1'b1;
                        else      lcl_mmio_dv  = 1'b1;
                        lcl_mmio_rsp  = ok;
                        lcl_mmio_dout = t.wr ? $urandom : d;
                        pend = 1'b0; last_strobe = k;
                    end else begin
                        if (t.wr) lcl_mmio_dv  = 1'($urandom);
                        else      lcl_mmio_ack = 1'($urandom);
                        lcl_mmio_rsp  = 1'($urandom);
                        lcl_mmio_dout = $urandom;
                    end
                end
                @(negedge clk);
                k++;
            end
        end
        chk({tag, ".rsp_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        chk({tag, ".err"}, 64'(rsp_err), 64'(e_err));
        chk({tag, ".timeout"}, 64'(rsp_timeout), 64'(e_to));
        chk({tag, ".rdata"}, rsp_rdata, e_rd);
        chk({tag, ".pulses"}, 64'(np), 64'(e_np));
        exp_k = (e_np == 0) ? 1 : (e_to ? last_pulse + TO + 1 : last_strobe + 1);
        chk({tag, ".rsp_latency"}, 64'(k), 64'(exp_k));
        for (int h = 0; h < t.rdy_delay; h++) begin
            lcl_mmio_ack  = 1'($urandom);
            lcl_mmio_dv   = 1'($urandom);
            lcl_mmio_rsp  = 1'($urandom);
            lcl_mmio_dout = $urandom;
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
            chk({tag, ".hold_err"}, 64'({rsp_err, rsp_timeout}), 64'({e_err, e_to}));
            chk({tag, ".hold_rdata"}, rsp_rdata, e_rd);
        end
        lcl_mmio_ack = 1'b0;
        lcl_mmio_dv  = 1'b0;
        rsp_ready    = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".release_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".release_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".release_flags"}, 64'({rsp_err, rsp_timeout}), 64'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".rsp_rdata"}, rsp_rdata, 64'd0);
        chk({tag, ".flags"}, 64'({rsp_err, rsp_timeout}), 64'd0);
        chk({tag, ".pulses"}, 64'({lcl_mmio_wr, lcl_mmio_rd}), 64'd0);
        chk({tag, ".addr"}, 64'(lcl_mmio_addr), 64'd0);
        chk({tag, ".din"}, 64'(lcl_mmio_din), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        txn_t        t;
        logic        e_err, e_to;
        logic [63:0] e_rd;
        int          e_np;

        vecs[0]  = '{mk(1, 0, 32'h10, 64'hA5A5_0001, 3, 1, 0, 0, 0, 0, 5), 0, 0, 64'h0, 1};
        vecs[1]  = '{mk(0, 1, 32'h20, 64'h0, 1, 1, 32'h1111_2222, 2, 1, 32'h3333_4444, 0),
                     0, 0, 64'h3333_4444_1111_2222, 2};
        vecs[2]  = '{mk(1, 1, 32'h40, 64'hCAFE_0002_BEEF_0001, 2, 0, 0, 1, 1, 0, 1), 1, 0, 64'h0, 1};
        vecs[3]  = '{mk(0, 0, 32'h80, 64'h0, NEVER, 1, 0, 0, 0, 0, 2), 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[4]  = '{mk(0, 1, 32'h44, 64'h0, 1, 1, 32'h1, 1, 1, 32'h2, 0), 1, 0, 64'h0, 0};
        vecs[5]  = '{mk(0, 0, 32'h30, 64'h0, TO, 1, 32'hDEAD_BEEF, 0, 0, 0, 0), 0, 0, 64'hDEAD_BEEF, 1};
        vecs[6]  = '{mk(0, 0, 32'h34, 64'h0, TO + 1, 1, 32'h1234, 0, 0, 0, 1),
                     1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[7]  = '{mk(1, 0, 32'h13, 64'h77, 1, 1, 0, 0, 0, 0, 0), 1, 0, 64'h0, 0};
        vecs[8]  = '{mk(0, 1, 32'h48, 64'h0, 1, 1, 32'hAAAA_0001, 3, 0, 32'h5555_0002, 0),
                     1, 0, 64'h5555_0002_AAAA_0001, 2};
        vecs[9]  = '{mk(0, 0, 32'h4C, 64'h0, 2, 0, 32'h0BAD_F00D, 0, 0, 0, 0), 1, 0, 64'h0BAD_F00D, 1};
        vecs[10] = '{mk(1, 1, 32'h50, 64'h2222_0000_1111_0000, 1, 1, 0, NEVER, 1, 0, 0), 1, 1, 64'h0, 2};
        vecs[11] = '{mk(0, 1, 32'h58, 64'h0, 1, 1, 32'h1357_9BDF, NEVER, 1, 0, 0),
                     1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        vecs[12] = '{mk(0, 1, 32'h0C, 64'h0, 1, 1, 0, 1, 1, 0, 0), 1, 0, 64'h0, 0};
        vecs[13] = '{mk(1, 1, 32'h60, 64'h0123_4567_89AB_CDEF, TO, 1, 0, TO, 1, 0, 0), 0, 0, 64'h0, 2};
        vecs[14] = '{mk(0, 0, 32'h2, 64'h0, 1, 1, 0, 0, 0, 0, 0), 1, 0, 64'h0, 0};

        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            run_txn(vecs[i].t, vecs[i].err, vecs[i].to, vecs[i].rdata, vecs[i].np, $sformatf("vec%0d", i));

        // Late strobes after a timeout must not disturb the idle sequencer.
        run_txn(vecs[3].t, vecs[3].err, vecs[3].to, vecs[3].rdata, vecs[3].np, "late.timeout");
        lcl_mmio_dv = 1'b1; lcl_mmio_ack = 1'b1; lcl_mmio_rsp = 1'b0; lcl_mmio_dout = 32'h5A5A_5A5A;
        @(negedge clk);
        lcl_mmio_dv = 1'b0; lcl_mmio_ack = 1'b0;
        @(negedge clk);
        chk("late.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("late.req_ready", 64'(req_ready), 64'd1);
        chk("late.pulses", 64'({lcl_mmio_wr, lcl_mmio_rd}), 64'd0);
        run_txn(vecs[0].t, vecs[0].err, vecs[0].to, vecs[0].rdata, vecs[0].np, "late.next");

        // Reset while the hi half of a 64b read is outstanding.
        req_valid = 1'b1; req_wr = 1'b0; req_dw = 1'b1; req_addr = 32'h60;
        chk("rstseq.ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstseq.lo_pulse", 64'({lcl_mmio_rd, lcl_mmio_addr}), 64'({1'b1, 32'h60}));
        @(negedge clk);
        lcl_mmio_dv = 1'b1; lcl_mmio_rsp = 1'b1; lcl_mmio_dout = 32'h9999_0000;
        @(negedge clk);
        lcl_mmio_dv = 1'b0;
        chk("rstseq.hi_pulse", 64'({lcl_mmio_rd, lcl_mmio_addr}), 64'({1'b1, 32'h64}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_values("rstseq");
        lcl_mmio_dv = 1'b1; lcl_mmio_dout = 32'h7777_7777;
        @(negedge clk);
        lcl_mmio_dv = 1'b0;
        chk("rstseq.stray_valid", 64'(rsp_valid), 64'd0);
        chk("rstseq.stray_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 80; i++) begin
            t.wr   = 1'($urandom);
            t.dw   = 1'($urandom);
            t.addr = $urandom & 32'h0000_FFF8;
            if ($urandom % 2 == 0) t.addr = t.addr | 32'h4;
            if ($urandom % 8 == 0) t.addr = t.addr | 32'(1 + $urandom % 3);
            t.wdata   = {$urandom, $urandom};
            t.lat_lo  = ($urandom % 10 == 0) ? TO + 1 + int'($urandom % 3) : 1 + int'($urandom % TO);
            t.lat_hi  = ($urandom % 10 == 0) ? TO + 1 + int'($urandom % 3) : 1 + int'($urandom % TO);
            t.rsp_lo  = ($urandom % 8 != 0);
            t.rsp_hi  = ($urandom % 8 != 0);
            t.dout_lo = $urandom;
            t.dout_hi = $urandom;
            t.rdy_delay = int'($urandom % 4);
            model(t, e_err, e_to, e_rd, e_np);
            run_txn(t, e_err, e_to, e_rd, e_np, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
